pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//   Owns the fetch PC and is the consumer side of jump/branch target generation.
//   Each cycle it selects the next PC: sequential PC+4, a jump target resolved in ID
//   (j/jal/jr), or a branch target resolved in EX.
//   It issues IF/ID flush strobes and holds a redirect that arrives during a pipeline stall.
//   It sits between the ID/EX target logic and the instruction memory address port.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   PC_W       32             PC / target width
// PORTS
//   Clk             in   1     clock, all state updates on rising edge
//   Rst             in   1     asynchronous, active-low reset
//   Stall           in   1     hazard stall: hold PC, do not consume redirects
//   JumpValid       in   1     ID stage has a resolved jump
//   JumpAddress     in   PC_W  jump target from ID
//   BranchValid     in   1     EX stage has a taken branch
//   BranchAddress   in   PC_W  branch target from EX
//   PCResult        out  PC_W  current fetch PC (registered)
//   PCPlus4         out  PC_W  PCResult + 4, combinational
//   FlushIF         out  1     kill instruction in IF/ID this edge
//   FlushID         out  1     kill instruction in ID/EX this edge
//   RedirectPending out  1     a held redirect is waiting (state HOLD)
//   AlignErr        out  1     1-cycle pulse: applied target had [1:0] != 00
// BEHAVIOUR
//   Reset (Rst=0, async): PCResult=RESET_PC, state RUN, pending regs cleared,
//     FlushIF=FlushID=AlignErr=0, RedirectPending=0.
//   Request select: BranchValid beats JumpValid (branch is the older instruction);
//     the losing jump is discarded (it lies on the wrong path).
//   States: RUN, HOLD (pending target + pending kind {JMP,BR} held in registers).
//   RUN, Stall=0, request present: PCResult <= target at the next edge, with [1:0] forced to 00.
//     FlushIF=1 in the same cycle (combinational). FlushID=1 also, for branch only.
//     Total redirect latency: the new PC is visible 1 cycle after the request.
//   RUN, Stall=0, no request: PCResult <= PCResult+4; the value wraps modulo 2^PC_W.
//   RUN, Stall=1, request present: PCResult holds; capture target+kind; go to HOLD.
//     No flush is asserted.
//   RUN, Stall=1, no request: PCResult holds.
//   HOLD, Stall=1: PCResult holds. A new request updates the pending target as follows:
//     - branch overwrites any pending entry;
//     - jump overwrites a pending jump only;
//     - jump is ignored if a branch is pending.
//   HOLD, Stall=0: apply the pending target, or a new request if it outranks the pending
//     one under the same rules. Flush as in RUN for the applied kind; return to RUN.
//   RedirectPending = (state==HOLD).
//   AlignErr is asserted in the cycle a target is applied with target[1:0]!=00.
//   Async reset mid-HOLD discards the pending target; the next fetch is from RESET_PC.
//   FlushIF/FlushID are never asserted while Stall=1.
// TESTING
//   1. Reset release, no requests, Stall=0 for 4 cycles
//      -> PCResult = 0, 4, 8, 12; all flushes 0.
//   2. PC=0x40: JumpValid=1, JumpAddress=0x100 for 1 cycle
//      -> FlushIF=1, FlushID=0 that cycle; next PCResult=0x100, then 0x104.
//   3. Same cycle: BranchValid=1 (BranchAddress 0x200) and JumpValid=1 (JumpAddress 0x300)
//      -> FlushIF=FlushID=1; next PCResult=0x200.
//   4. Stall=1 with JumpValid=1 (0x80); 2 stall cycles; branch 0x90 on 2nd cycle
//      -> RedirectPending=1, PC held, no flush.
//      Stall drops -> FlushIF=FlushID=1; next PC=0x90.
//   5. HOLD with pending branch 0xA0; JumpValid=1 (0xF0) while stalled; Stall drops
//      -> next PC=0xA0 (jump ignored).
//   6. PC=0xFFFF_FFFC, no request -> next PC=0x0.
//      Jump to 0x103 -> PC=0x100, AlignErr pulses 1 cycle.
//      Rst=0 asserted mid-HOLD -> PC=RESET_PC immediately, RedirectPending=0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: picks the next PC from PC+4, an ID jump or an EX branch.
// It also drives the IF/ID flush strobes and holds a redirect that arrives during a stall.
module pc_redirect_unit #(
    parameter int unsigned          PC_W     = 32,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Stall,
    input  logic            JumpValid,
    input  logic [PC_W-1:0] JumpAddress,
    input  logic            BranchValid,
    input  logic [PC_W-1:0] BranchAddress,
    output logic [PC_W-1:0] PCResult,
    output logic [PC_W-1:0] PCPlus4,
    output logic            FlushIF,
    output logic            FlushID,
    output logic            RedirectPending,
    output logic            AlignErr
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_addr_q, pend_addr_d;
    logic              pend_br_q, pend_br_d;

    logic              req_any;
    logic              req_br;
    logic [PC_W-1:0]   req_addr;
    logic [PC_W-1:0]   pc_plus4;
    logic              apply;
    logic              apply_br;
    logic [PC_W-1:0]   apply_addr;

    // The branch is the older instruction, so it wins and the jump is on the wrong path
    always_comb begin
        req_any  = BranchValid | JumpValid;
        req_br   = BranchValid;
        req_addr = BranchValid ? BranchAddress : JumpAddress;
        pc_plus4 = pc_q + PC_W'(4);
    end

    // Next-state, next-PC and pending-redirect bookkeeping
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_br_d   = pend_br_q;
        apply       = 1'b0;
        apply_br    = 1'b0;
        apply_addr  = '0;

        case (state_q)
            ST_RUN: begin
                if (!Stall) begin
                    if (req_any) begin
                        apply      = 1'b1;
                        apply_br   = req_br;
                        apply_addr = req_addr;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (req_any) begin
                    pend_addr_d = req_addr;
                    pend_br_d   = req_br;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Stall) begin
                    // A pending branch can only be displaced by a younger-path-free branch
                    if (BranchValid) begin
                        pend_addr_d = BranchAddress;
                        pend_br_d   = 1'b1;
                    end else if (JumpValid && !pend_br_q) begin
                        pend_addr_d = JumpAddress;
                        pend_br_d   = 1'b0;
                    end
                end else begin
                    apply   = 1'b1;
                    state_d = ST_RUN;
                    if (BranchValid) begin
                        apply_br   = 1'b1;
                        apply_addr = BranchAddress;
                    end else if (JumpValid && !pend_br_q) begin
                        apply_br   = 1'b0;
                        apply_addr = JumpAddress;
                    end else begin
                        apply_br   = pend_br_q;
                        apply_addr = pend_addr_q;
                    end
                    pend_addr_d = '0;
                    pend_br_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (apply) begin
            pc_d = apply_addr & ~PC_W'(3);
        end
    end

    // State, PC and pending-target registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
            pend_br_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pend_br_q   <= pend_br_d;
        end
    end

    // Output drive; flush and alignment strobes track the cycle a target is applied
    always_comb begin
        PCResult        = pc_q;
        PCPlus4         = pc_plus4;
        FlushIF         = apply;
        FlushID         = apply & apply_br;
        AlignErr        = apply & (|apply_addr[1:0]);
        RedirectPending = (state_q == ST_HOLD);
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        JumpValid;
    logic [31:0] JumpAddress;
    logic        BranchValid;
    logic [31:0] BranchAddress;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic        FlushIF;
    logic        FlushID;
    logic        RedirectPending;
    logic        AlignErr;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Stall          (Stall),
        .JumpValid      (JumpValid),
        .JumpAddress    (JumpAddress),
        .BranchValid    (BranchValid),
        .BranchAddress  (BranchAddress),
        .PCResult       (PCResult),
        .PCPlus4        (PCPlus4),
        .FlushIF        (FlushIF),
        .FlushID        (FlushID),
        .RedirectPending(RedirectPending),
        .AlignErr       (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational strobes before the edge, PC after it.
    task automatic cyc(input string tag, input logic st,
                       input logic jv, input logic [31:0] ja,
                       input logic bv, input logic [31:0] ba,
                       input logic e_fif, input logic e_fid, input logic e_al,
                       input logic e_pend, input logic [31:0] e_pc);
        Stall         = st;
        JumpValid     = jv;
        JumpAddress   = ja;
        BranchValid   = bv;
        BranchAddress = ba;
        @(negedge Clk);
        check({tag, ".fif"},  32'(FlushIF),         32'(e_fif));
        check({tag, ".fid"},  32'(FlushID),         32'(e_fid));
        check({tag, ".al"},   32'(AlignErr),        32'(e_al));
        check({tag, ".pend"}, 32'(RedirectPending), 32'(e_pend));
        @(posedge Clk);
        #1;
        check({tag, ".pc"},   PCResult, e_pc);
        check({tag, ".pc4"},  PCPlus4,  e_pc + 32'd4);
    endtask

    initial begin
        Rst = 1'b0; Stall = 1'b0; JumpValid = 1'b0; JumpAddress = '0;
        BranchValid = 1'b0; BranchAddress = '0;
        #1;
        check("rst.pc",   PCResult, 32'h0);
        check("rst.pend", 32'(RedirectPending), 32'h0);
        check("rst.fif",  32'(FlushIF), 32'h0);
        check("rst.fid",  32'(FlushID), 32'h0);
        check("rst.al",   32'(AlignErr), 32'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        check("rel.pc", PCResult, 32'h0);

        // Sequential fetch
        cyc("seq1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        cyc("seq2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8);
        cyc("seq3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC);
        cyc("seq4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10);

        // Jumps
        cyc("j40",  0, 1, 32'h40,  0, 0, 1, 0, 0, 0, 32'h40);
        cyc("j100", 0, 1, 32'h100, 0, 0, 1, 0, 0, 0, 32'h100);
        cyc("seq5", 0, 0, 0,       0, 0, 0, 0, 0, 0, 32'h104);

        // Branch beats same-cycle jump
        cyc("bvj",  0, 1, 32'h300, 1, 32'h200, 1, 1, 0, 0, 32'h200);

        // Stalled jump then stalled branch overwrites; applied on release
        cyc("sj80", 1, 1, 32'h80, 0, 0,       0, 0, 0, 0, 32'h200);
        cyc("sb90", 1, 0, 0,      1, 32'h90,  0, 0, 0, 1, 32'h200);
        cyc("rel1", 0, 0, 0,      0, 0,       1, 1, 0, 1, 32'h90);
        cyc("seq6", 0, 0, 0,      0, 0,       0, 0, 0, 0, 32'h94);

        // Pending branch ignores a later jump
        cyc("sbA0", 1, 0, 0,       1, 32'hA0, 0, 0, 0, 0, 32'h94);
        cyc("sjF0", 1, 1, 32'hF0,  0, 0,      0, 0, 0, 1, 32'h94);
        cyc("rel2", 0, 0, 0,       0, 0,      1, 1, 0, 1, 32'hA0);

        // Pending jump replaced by a newer jump
        cyc("sj300", 1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 32'hA0);
        cyc("sj400", 1, 1, 32'h400, 0, 0, 0, 0, 0, 1, 32'hA0);
        cyc("rel3",  0, 0, 0,       0, 0, 1, 0, 0, 1, 32'h400);

        // Pending jump outranked by a branch arriving on release
        cyc("sj500", 1, 1, 32'h500, 0, 0,       0, 0, 0, 0, 32'h400);
        cyc("rb600", 0, 0, 0,       1, 32'h600, 1, 1, 0, 1, 32'h600);

        // Wrap and alignment
        cyc("jtop", 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        cyc("wrap", 0, 0, 0,             0, 0, 0, 0, 0, 0, 32'h0);
        cyc("j103", 0, 1, 32'h103,       0, 0, 1, 0, 1, 0, 32'h100);
        cyc("seq7", 0, 0, 0,             0, 0, 0, 0, 0, 0, 32'h104);

        // Async reset while holding a redirect
        cyc("sj700", 1, 1, 32'h700, 0, 0, 0, 0, 0, 0, 32'h104);
        check("hold.pend", 32'(RedirectPending), 32'h1);
        Rst = 1'b0;
        #1;
        check("mrst.pc",   PCResult, 32'h0);
        check("mrst.pend", 32'(RedirectPending), 32'h0);
        Stall = 1'b0; JumpValid = 1'b0; JumpAddress = '0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        cyc("post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
